stream_cmd_sequencer: RTL and testbench
=======================================

// Module: stream_cmd_sequencer
// PURPOSE
//  Upstream job expander for the XOR stream unit: accepts one job (base address, count, key) and emits
//  'count' read addresses on cmdA plus 'count' key words on cmdB, each channel under its own valid/ready handshake.
//  Its outputs connect directly to the stream unit's io_cmdA / io_cmdB inputs.
//  Turns one descriptor into a burst of memory-read-and-XOR operations.
// PARAMETERS
//  ADDR_W  8          address width; matches the stream unit memory depth 2**ADDR_W
//  DATA_W  32         key / cmdB payload width
//  CNT_W   ADDR_W+1   job count width; legal range 0..2**ADDR_W
// PORTS
//  clk                    in   1       single clock, rising edge
//  resetn                 in   1       asynchronous, active-low reset
//  io_job_valid           in   1       job descriptor valid
//  io_job_ready           out  1       sequencer can accept a job
//  io_job_payload_address in   ADDR_W  base read address
//  io_job_payload_count   in   CNT_W   number of commands per channel
//  io_job_payload_key     in   DATA_W  key word sent on cmdB
//  io_cmdA_valid          out  1       address command valid
//  io_cmdA_ready          in   1       downstream accepts the address
//  io_cmdA_payload        out  ADDR_W  read address
//  io_cmdB_valid          out  1       key command valid
//  io_cmdB_ready          in   1       downstream accepts the key
//  io_cmdB_payload        out  DATA_W  key word
//  io_busy                out  1       a job is in progress
// BEHAVIOUR
//  - Reset values (resetn=0, async): state=IDLE; io_job_ready=1; io_cmdA_valid=0; io_cmdB_valid=0; io_busy=0.
//    Counters are 0; base, count and key registers are 0.
//  - FSM IDLE: io_job_ready=1. On job fire (valid&ready), register address, count and key.
//    If count!=0, go to RUN. If count==0, the job is consumed and no commands are issued (stay IDLE).
//  - FSM RUN: io_job_ready=0, io_busy=1. Counters idxA and idxB are independent.
//    io_cmdA_valid = (idxA<count); io_cmdA_payload = base+idxA, truncated to ADDR_W (wraps 255->0).
//    io_cmdB_valid = (idxB<count); io_cmdB_payload = key.
//    A counter increments only on its own channel's fire, so a payload is held stable while valid&!ready.
//    Valid never drops before the handshake completes.
//  - The channels may skew arbitrarily; cmdA may complete all beats before cmdB, or the reverse.
//  - RUN->IDLE in the cycle where the last outstanding fire occurs (both idx==count after the update).
//    io_job_ready=1 in the next cycle: there is one bubble between jobs. Simultaneous final fires on A and B are legal.
//  - First command valid is asserted the cycle after job fire (1-cycle latency). No combinational path from ready to valid.
//  - Reset mid-job aborts immediately: valids drop asynchronously and the partial burst is discarded.
// CONFIGURATION
//  STREAM_CMD_SEQ_INDEX_XOR_EN defined:
//    io_cmdB_payload = key ^ zero_extend(idxB), giving a distinct key per beat.
//  Undefined: io_cmdB_payload = key, constant for the whole job.
// STRUCTURE
//  Package stream_cmd_seq_pkg: state enum {IDLE,RUN}; ADDR_W/DATA_W/CNT_W defaults; job struct {address,count,key}.
//  Sub-module stream_cmd_seq_chan: per-channel counter, valid generation and done flag.
//    Instantiated twice (A and B). Inputs: start, count, fire. Outputs: idx, valid, done.
// TESTING
//  1. Job addr=0x10,cnt=4,key=0xA5A5A5A5, both readies=1 -> cmdA 0x10..0x13 on consecutive cycles;
//     cmdB 4x 0xA5A5A5A5; io_busy high for 4 cycles.
//  2. Wrap: addr=0xFE,cnt=4 -> cmdA 0xFE,0xFF,0x00,0x01.
//  3. Skew: cmdB_ready=0 until cmdA finishes a cnt=3 job -> cmdB payload is held, 3 beats follow, then IDLE.
//  4. Back-pressure: random ready toggling on both channels -> payload stable while valid&!ready, no beat lost or duplicated.
//  5. cnt=0 job -> consumed in 1 cycle; no cmd valid; next job is accepted on the following cycle.
//  6. resetn low mid-job (after 2 of 5 beats) -> valids drop at once; after release, io_job_ready=1 and no stale beats.
//     With STREAM_CMD_SEQ_INDEX_XOR_EN, also check that key=0 yields payloads 0,1,2,...

Source files
------------

// File: rtl/stream_cmd_seq_pkg.sv
// rtl/stream_cmd_seq_pkg.sv - shared types and default widths for the stream command sequencer
package stream_cmd_seq_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = DEF_ADDR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_CNT_W-1:0]  count;
        logic [DEF_DATA_W-1:0] key;
    } job_t;

endpackage

// File: rtl/stream_cmd_seq_chan.sv
// rtl/stream_cmd_seq_chan.sv - per-channel beat counter with valid and done generation
module stream_cmd_seq_chan #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_fire,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_valid,
    output logic             o_done
);

    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] w_idx_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx <= '0;
        end else if (i_start) begin
            r_idx <= '0;
        end else if (i_fire) begin
            r_idx <= w_idx_nxt;
        end
    end

    assign w_idx_nxt = r_idx + {{(CNT_W-1){1'b0}}, i_fire};

    // valid depends only on registered state, so ready never loops back into it
    assign o_valid = i_run && (r_idx < i_count);
    assign o_done  = (w_idx_nxt == i_count);
    assign o_idx   = r_idx;

endmodule

// File: rtl/stream_cmd_sequencer.sv
// rtl/stream_cmd_sequencer.sv - expands one job into address/key command bursts (option: STREAM_CMD_SEQ_INDEX_XOR_EN)
module stream_cmd_sequencer
    import stream_cmd_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              io_job_valid,
    output logic              io_job_ready,
    input  logic [ADDR_W-1:0] io_job_payload_address,
    input  logic [CNT_W-1:0]  io_job_payload_count,
    input  logic [DATA_W-1:0] io_job_payload_key,
    output logic              io_cmdA_valid,
    input  logic              io_cmdA_ready,
    output logic [ADDR_W-1:0] io_cmdA_payload,
    output logic              io_cmdB_valid,
    input  logic              io_cmdB_ready,
    output logic [DATA_W-1:0] io_cmdB_payload,
    output logic              io_busy
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_key;

    logic              w_job_fire;
    logic              w_run;
    logic              w_fire_a;
    logic              w_fire_b;
    logic              w_valid_a;
    logic              w_valid_b;
    logic              w_done_a;
    logic              w_done_b;
    logic [CNT_W-1:0]  w_idx_a;
    logic [CNT_W-1:0]  w_idx_b;
    logic              w_unused_bits;

    assign w_job_fire = io_job_valid && io_job_ready;
    assign w_run      = (r_state == RUN);
    assign w_fire_a   = w_valid_a && io_cmdA_ready;
    assign w_fire_b   = w_valid_b && io_cmdB_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // a zero-count job is accepted and dropped without leaving IDLE
    always_comb begin
        w_state_nxt  = r_state;
        io_job_ready = 1'b0;
        io_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                io_job_ready = 1'b1;
                if (w_job_fire && (io_job_payload_count != '0)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                io_busy = 1'b1;
                if (w_done_a && w_done_b) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base  <= '0;
            r_count <= '0;
            r_key   <= '0;
        end else if (w_job_fire) begin
            r_base  <= io_job_payload_address;
            r_count <= io_job_payload_count;
            r_key   <= io_job_payload_key;
        end
    end

    stream_cmd_seq_chan #(
        .CNT_W (CNT_W)
    ) u_chan_a (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (w_job_fire),
        .i_run   (w_run),
        .i_count (r_count),
        .i_fire  (w_fire_a),
        .o_idx   (w_idx_a),
        .o_valid (w_valid_a),
        .o_done  (w_done_a)
    );

    stream_cmd_seq_chan #(
        .CNT_W (CNT_W)
    ) u_chan_b (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (w_job_fire),
        .i_run   (w_run),
        .i_count (r_count),
        .i_fire  (w_fire_b),
        .o_idx   (w_idx_b),
        .o_valid (w_valid_b),
        .o_done  (w_done_b)
    );

    assign io_cmdA_valid   = w_valid_a;
    assign io_cmdB_valid   = w_valid_b;
    // address wraps modulo the memory depth
    assign io_cmdA_payload = r_base + w_idx_a[ADDR_W-1:0];

`ifdef STREAM_CMD_SEQ_INDEX_XOR_EN
    assign io_cmdB_payload = r_key ^ DATA_W'(w_idx_b);
    assign w_unused_bits   = w_idx_a[CNT_W-1];
`else
    assign io_cmdB_payload = r_key;
    assign w_unused_bits   = ^{w_idx_a[CNT_W-1], w_idx_b};
`endif

endmodule

// File: tb/tb_stream_cmd_sequencer.sv
// tb/tb_stream_cmd_sequencer.sv - directed self-checking bench for stream_cmd_sequencer
module tb_stream_cmd_sequencer;
    import stream_cmd_seq_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        io_job_valid = 1'b0;
    logic        io_job_ready;
    logic [7:0]  io_job_payload_address = '0;
    logic [8:0]  io_job_payload_count = '0;
    logic [31:0] io_job_payload_key = '0;
    logic        io_cmdA_valid;
    logic        rdy_a = 1'b1;
    logic [7:0]  io_cmdA_payload;
    logic        io_cmdB_valid;
    logic        rdy_b = 1'b1;
    logic [31:0] io_cmdB_payload;
    logic        io_busy;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    stream_cmd_sequencer dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .io_job_valid           (io_job_valid),
        .io_job_ready           (io_job_ready),
        .io_job_payload_address (io_job_payload_address),
        .io_job_payload_count   (io_job_payload_count),
        .io_job_payload_key     (io_job_payload_key),
        .io_cmdA_valid          (io_cmdA_valid),
        .io_cmdA_ready          (rdy_a),
        .io_cmdA_payload        (io_cmdA_payload),
        .io_cmdB_valid          (io_cmdB_valid),
        .io_cmdB_ready          (rdy_b),
        .io_cmdB_payload        (io_cmdB_payload),
        .io_busy                (io_busy)
    );

    always @(posedge clk) cyc++;

    // mode 0: always ready, 1: random, 2: cmdB stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                rdy_a = 1'($urandom);
                rdy_b = 1'($urandom);
            end
            2: begin
                rdy_a = 1'b1;
                rdy_b = 1'b0;
            end
            default: begin
                rdy_a = 1'b1;
                rdy_b = 1'b1;
            end
        endcase
    end

    logic [7:0]  qa[$];
    logic [31:0] qb[$];
    int          busy_cnt = 0;
    int          hold_seen = 0;
    int          hold_err = 0;
    logic        pa_stall = 1'b0;
    logic        pb_stall = 1'b0;
    logic [7:0]  pa = '0;
    logic [31:0] pb = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            pa_stall = 1'b0;
            pb_stall = 1'b0;
        end else begin
            if (pa_stall) begin
                hold_seen++;
                if (!io_cmdA_valid || io_cmdA_payload !== pa) hold_err++;
            end
            if (pb_stall) begin
                hold_seen++;
                if (!io_cmdB_valid || io_cmdB_payload !== pb) hold_err++;
            end
            if (io_cmdA_valid && rdy_a) qa.push_back(io_cmdA_payload);
            if (io_cmdB_valid && rdy_b) qb.push_back(io_cmdB_payload);
            pa_stall = io_cmdA_valid && !rdy_a;
            pb_stall = io_cmdB_valid && !rdy_b;
            pa = io_cmdA_payload;
            pb = io_cmdB_payload;
            if (io_busy) busy_cnt++;
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_b(input logic [31:0] k, input int i);
`ifdef STREAM_CMD_SEQ_INDEX_XOR_EN
        return k ^ 32'(i);
`else
        return k ^ 32'(i & 0);
`endif
    endfunction

    task automatic send_job(input job_t j);
        bit got = 1'b0;
        bit acc = 1'b0;
        io_job_valid           = 1'b1;
        io_job_payload_address = j.address;
        io_job_payload_count   = j.count;
        io_job_payload_key     = j.key;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = io_job_ready;
            @(posedge clk);
            #1;
            if (got) begin
                acc = 1'b1;
                break;
            end
        end
        io_job_valid = 1'b0;
        if (!acc) check_vec("job_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk);
            #1;
            if (!io_busy && io_job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_vec("idle_timeout", 64'(ok), 1);
    endtask

    task automatic check_stream(input string tag, input int ba, input int bb, input job_t j);
        check_vec({tag, ".nA"}, 64'(qa.size() - ba), 64'(j.count));
        check_vec({tag, ".nB"}, 64'(qb.size() - bb), 64'(j.count));
        for (int i = 0; i < int'(j.count); i++) begin
            check_vec({tag, ".A"}, 64'(qa[ba+i]), 64'(8'(j.address + 8'(i))));
            check_vec({tag, ".B"}, 64'(qb[bb+i]), 64'(exp_b(j.key, i)));
        end
    endtask

    int   ba, bb, bc, c0;
    job_t jb;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst.job_ready", 64'(io_job_ready), 1);
        check_vec("rst.cmdA_valid", 64'(io_cmdA_valid), 0);
        check_vec("rst.cmdB_valid", 64'(io_cmdB_valid), 0);
        check_vec("rst.busy", 64'(io_busy), 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // basic burst
        ba = qa.size(); bb = qb.size(); bc = busy_cnt;
        jb = '{address: 8'h10, count: 9'd4, key: 32'hA5A5A5A5};
        send_job(jb);
        wait_idle(20);
        check_stream("t1", ba, bb, jb);
        check_vec("t1.busy_cycles", 64'(busy_cnt - bc), 4);

        // address wrap
        ba = qa.size(); bb = qb.size();
        jb = '{address: 8'hFE, count: 9'd4, key: 32'h0F0F0001};
        send_job(jb);
        wait_idle(20);
        check_stream("t2", ba, bb, jb);
        check_vec("t2.A2", 64'(qa[ba+2]), 64'h00);

        // cmdB held off until cmdA drains
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        ba = qa.size(); bb = qb.size();
        jb = '{address: 8'h20, count: 9'd3, key: 32'h12345678};
        send_job(jb);
        for (int k = 0; k < 20 && (qa.size() - ba) < 3; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_vec("t3.cmdA_valid", 64'(io_cmdA_valid), 0);
        check_vec("t3.cmdB_valid", 64'(io_cmdB_valid), 1);
        check_vec("t3.cmdB_hold", 64'(io_cmdB_payload), 64'(exp_b(32'h12345678, 0)));
        check_vec("t3.busy", 64'(io_busy), 1);
        check_vec("t3.nB_early", 64'(qb.size() - bb), 0);
        rdy_mode = 0;
        wait_idle(20);
        check_stream("t3", ba, bb, jb);

        // random back-pressure
        rdy_mode = 1;
        ba = qa.size(); bb = qb.size();
        jb = '{address: 8'h40, count: 9'd6, key: 32'hDEADBEEF};
        send_job(jb);
        wait_idle(300);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check_stream("t4", ba, bb, jb);
        check_vec("t4.hold_err", 64'(hold_err), 0);
        check_vec("t4.hold_seen", 64'(hold_seen != 0), 1);

        // zero-count job then an immediate follow-on
        ba = qa.size(); bb = qb.size();
        c0 = cyc;
        send_job('{address: 8'h30, count: 9'd0, key: 32'h55555555});
        check_vec("t5.accept_cycles", 64'(cyc - c0), 1);
        check_vec("t5.job_ready", 64'(io_job_ready), 1);
        check_vec("t5.busy", 64'(io_busy), 0);
        check_vec("t5.cmdA_valid", 64'(io_cmdA_valid), 0);
        check_vec("t5.cmdB_valid", 64'(io_cmdB_valid), 0);
        c0 = cyc;
        jb = '{address: 8'h77, count: 9'd1, key: 32'hCAFEF00D};
        send_job(jb);
        check_vec("t5.next_accept_cycles", 64'(cyc - c0), 1);
        wait_idle(20);
        check_stream("t5", ba, bb, jb);

        // reset in the middle of a burst
        ba = qa.size(); bb = qb.size();
        send_job('{address: 8'h50, count: 9'd5, key: 32'h11112222});
        repeat (2) @(posedge clk);
        #1;
        check_vec("t6.pre_valid", 64'(io_cmdA_valid), 1);
        resetn = 1'b0;
        #1;
        check_vec("t6.cmdA_valid", 64'(io_cmdA_valid), 0);
        check_vec("t6.cmdB_valid", 64'(io_cmdB_valid), 0);
        check_vec("t6.busy", 64'(io_busy), 0);
        check_vec("t6.job_ready", 64'(io_job_ready), 1);
        check_vec("t6.nA_at_reset", 64'(qa.size() - ba), 2);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_vec("t6.nA_after", 64'(qa.size() - ba), 2);
        check_vec("t6.nB_after", 64'(qb.size() - bb), 2);
        check_vec("t6.idle_valid", 64'(io_cmdA_valid | io_cmdB_valid), 0);
        check_vec("t6.idle_ready", 64'(io_job_ready), 1);

`ifdef STREAM_CMD_SEQ_INDEX_XOR_EN
        ba = qa.size(); bb = qb.size();
        jb = '{address: 8'h00, count: 9'd3, key: 32'h0};
        send_job(jb);
        wait_idle(20);
        for (int i = 0; i < 3; i++) begin
            check_vec("t7.B_index", 64'(qb[bb+i]), 64'(i));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
